// File: rtl/tt_check_pkg.sv
// Shared types and constants for the truth table checker.
// Imported by the checker top and its settle timer.
package tt_check_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int vec_count(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter that holds each stimulus vector for a settle interval.
// Loads on request, counts down to zero and then stays there.
module tt_settle_timer
  import tt_check_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into a gate under test and compares its
// output against an expected truth table, reporting errors on done.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE = 2,
  parameter logic [vec_count(N_IN)-1:0] EXPECT = 8'b1000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_err_valid,
  output logic [N_IN-1:0] first_err_idx
);

  localparam int VEC = vec_count(N_IN);
  localparam logic [SETTLE_W-1:0] LOAD =
    SETTLE_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST =
    N_IN'(VEC - 1);

  state_t state;
  state_t state_n;

  logic          accept;
  logic          mismatch;
  logic          last;
  logic          zero;
  logic          t_load;
  logic          t_dec;
  logic [N_IN:0] err_n;

  assign accept   = (state == IDLE) && start;
  assign mismatch = (dut_out != EXPECT[stim]);
  assign last     = (stim == LAST);
  assign err_n    = err_count + (N_IN+1)'(mismatch);

  // Reload the settle interval for the first and every following vector.
  assign t_load = accept ||
                  ((state == SAMPLE) && !last);
  assign t_dec  = (state == DRIVE);

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (LOAD),
    .dec      (t_dec),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = DRIVE;
      DRIVE:   if (zero) state_n = SAMPLE;
      SAMPLE:  state_n = last ? DONE : DRIVE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            stim            <= '0;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
          end
        end
        DRIVE: begin
        end
        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_n;
            if (!first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_idx   <= stim;
            end
          end
          // The last vector ends the sweep without advancing stim.
          if (last) begin
            done <= 1'b1;
            busy <= 1'b0;
            pass <= (err_n == '0);
          end else begin
            stim <= stim + 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
